// File: rtl/chan_ctrl_pkg.sv
// Shared definitions for the channelizer reconfiguration controller:
// state encoding, legal FFT size bounds and the power-up size.
package chan_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_RESET,
        S_SETTLE,
        S_CONFIG
    } state_e;

    localparam int unsigned MIN_FFT_SIZE     = 8;
    localparam int unsigned MAX_FFT_SIZE     = 2048;
    localparam int unsigned DEFAULT_FFT_SIZE = 128;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/chan_size_decode.sv
// Maps a 12-bit FFT size to a legality flag (power of two in 8..2048)
// and its log2 for the FFT config word.
module chan_size_decode
    import chan_ctrl_pkg::*;
(
    input  logic [11:0] size,
    output logic        legal,
    output logic [4:0]  nfft
);

    always_comb begin
        nfft = '0;
        // Highest set bit; only meaningful when the size is a single power of two.
        for (int i = 0; i < 12; i++) begin
            if (size[i]) nfft = 5'(i);
        end
        legal = ($countones(size) == 1) && (size >= 12'(MIN_FFT_SIZE)) &&
                (size <= 12'(MAX_FFT_SIZE));
    end

endmodule

// File: rtl/chan_reconfig_ctrl.sv
// Sequences a channelizer size change: drain the current frame, pulse the
// datapath reset, let it settle, then send one FFT config beat.
module chan_reconfig_ctrl #(
    parameter int unsigned RESET_CYCLES     = 8,
    parameter int unsigned SETTLE_CYCLES    = 4,
    parameter int unsigned DRAIN_TIMEOUT    = 4096,
    parameter int unsigned DEFAULT_FFT_SIZE = chan_ctrl_pkg::DEFAULT_FFT_SIZE
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [11:0] fft_size_req,
    input  logic        frame_done,
    output logic        in_gate,
    output logic        dp_reset,
    output logic        fft_aresetn,
    output logic [11:0] fft_size_out,
    output logic        cfg_tvalid,
    output logic [15:0] cfg_tdata,
    input  logic        cfg_tready,
    output logic        busy,
    output logic        reconfig_done,
    output logic        err_invalid,
    output logic        drain_timeout
);
    import chan_ctrl_pkg::*;

    localparam int unsigned CNT_MAX = max3(RESET_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      size_q, size_d;
    logic [4:0]       nfft_q, nfft_d;
    logic [11:0]      err_val_q, err_val_d;
    logic             err_seen_q, err_seen_d;
    logic             done_d, err_d, tmo_d;
    logic             req_legal, req_change;
    logic [4:0]       req_nfft;

    chan_size_decode u_req_decode (
        .size  (fft_size_req),
        .legal (req_legal),
        .nfft  (req_nfft)
    );

    assign req_change = req_legal && (fft_size_req != size_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
        size_d     = size_q;
        nfft_d     = nfft_q;
        err_val_d  = err_val_q;
        err_seen_d = err_seen_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tmo_d      = 1'b0;

        unique case (state_q)
            S_RUN: begin
                cnt_d = '0;
                if (req_change) begin
                    state_d = S_DRAIN;
                end else if (!req_legal && (fft_size_req != size_q) &&
                             !(err_seen_q && (err_val_q == fft_size_req))) begin
                    // Report each distinct bad value once, not every cycle it is held.
                    err_d      = 1'b1;
                    err_seen_d = 1'b1;
                    err_val_d  = fft_size_req;
                end
                if (req_legal) err_seen_d = 1'b0;
            end
            S_DRAIN: begin
                if (frame_done || (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1))) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    tmo_d   = !frame_done;
                    if (req_legal) begin
                        size_d = fft_size_req;
                        nfft_d = req_nfft;
                    end
                end
            end
            S_RESET: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CONFIG;
                    cnt_d   = '0;
                end
            end
            S_CONFIG: begin
                if (cfg_tvalid && cfg_tready) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    // A request that arrived mid-sequence restarts without reopening the gate.
                    state_d = req_change ? S_DRAIN : S_RUN;
                end
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_RESET;
            cnt_q         <= '0;
            size_q        <= 12'(DEFAULT_FFT_SIZE);
            nfft_q        <= 5'($clog2(DEFAULT_FFT_SIZE));
            err_val_q     <= '0;
            err_seen_q    <= 1'b0;
            in_gate       <= 1'b0;
            dp_reset      <= 1'b1;
            fft_aresetn   <= 1'b0;
            cfg_tvalid    <= 1'b0;
            cfg_tdata     <= {11'b0, 5'($clog2(DEFAULT_FFT_SIZE))};
            busy          <= 1'b1;
            reconfig_done <= 1'b0;
            err_invalid   <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            size_q        <= size_d;
            nfft_q        <= nfft_d;
            err_val_q     <= err_val_d;
            err_seen_q    <= err_seen_d;
            in_gate       <= (state_d == S_RUN);
            dp_reset      <= (state_d == S_RESET);
            fft_aresetn   <= (state_d != S_RESET);
            cfg_tvalid    <= (state_d == S_CONFIG);
            cfg_tdata     <= {11'b0, nfft_d};
            busy          <= (state_d != S_RUN);
            reconfig_done <= done_d;
            err_invalid   <= err_d;
            drain_timeout <= tmo_d;
        end
    end

    assign fft_size_out = size_q;

endmodule
